// File: rtl/multicore_monitor_if.sv
// Bundle of the supervisor's run-control, per-core inputs and result outputs.
// master drives start/strobes/results; slave is the monitor itself.
interface multicore_monitor_if #(
    parameter int CORES    = 16,
    parameter int RESULT_W = 8,
    parameter int SUM_W    = 12,
    parameter int CYCLE_W  = 16
);
    logic                      start;
    logic [CORES-1:0]          core_strobe;
    logic [CORES*RESULT_W-1:0] core_result;
    logic                      busy;
    logic [CORES-1:0]          done_mask;
    logic [CYCLE_W-1:0]        cycles;
    logic                      cycles_sat;
    logic [SUM_W-1:0]          total;
    logic                      total_sat;
    logic                      total_valid;

    modport master (
        output start, core_strobe, core_result,
        input  busy, done_mask, cycles, cycles_sat, total, total_sat, total_valid
    );

    modport slave (
        input  start, core_strobe, core_result,
        output busy, done_mask, cycles, cycles_sat, total, total_sat, total_valid
    );
endinterface

// File: rtl/multicore_monitor.sv
// Multicore run supervisor: per-core done detection, saturating run-cycle
// counter and sequential saturating sum of core results.
module multicore_monitor #(
    parameter int CORES    = 16,
    parameter int RESULT_W = 8,
    parameter int SUM_W    = 12,
    parameter int CYCLE_W  = 16
) (
    input logic                clk,
    input logic                reset,
    multicore_monitor_if.slave mon
);
    localparam int IDX_W = (CORES > 1) ? $clog2(CORES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CORES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SUM,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CORES-1:0]   strobe_q;
    logic [CORES-1:0]   fall;
    logic               all_done;
    logic [IDX_W-1:0]   idx_q;
    logic               busy_q;
    logic [CORES-1:0]   done_q;
    logic [CYCLE_W-1:0] cycles_q;
    logic [CYCLE_W-1:0] cycles_inc;
    logic               cycles_sat_q;
    logic [SUM_W-1:0]   total_q;
    logic               total_sat_q;
    logic               total_valid_q;
    logic [RESULT_W-1:0] cur_result;
    logic [SUM_W:0]     sum_ext;

    assign fall       = strobe_q & ~mon.core_strobe;
    assign all_done   = &(done_q | fall);
    assign cycles_inc = cycles_q + CYCLE_W'(1);
    // Results are read live during SUM, one core per cycle.
    assign cur_result = mon.core_result[int'(idx_q) * RESULT_W +: RESULT_W];
    assign sum_ext    = {1'b0, total_q} + {{(SUM_W + 1 - RESULT_W){1'b0}}, cur_result};

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (mon.start) state_d = RUN;
            RUN:        if (all_done) state_d = SUM;
            SUM:        if (idx_q == LAST_IDX) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            strobe_q      <= '0;
            idx_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= '0;
            cycles_q      <= '0;
            cycles_sat_q  <= 1'b0;
            total_q       <= '0;
            total_sat_q   <= 1'b0;
            total_valid_q <= 1'b0;
        end else begin
            strobe_q <= mon.core_strobe;
            unique case (state_q)
                IDLE, DONE: begin
                    if (mon.start) begin
                        idx_q         <= '0;
                        busy_q        <= 1'b1;
                        done_q        <= '0;
                        cycles_q      <= '0;
                        cycles_sat_q  <= 1'b0;
                        total_q       <= '0;
                        total_sat_q   <= 1'b0;
                        total_valid_q <= 1'b0;
                    end else if (state_q == DONE) begin
                        busy_q        <= 1'b0;
                        total_valid_q <= 1'b1;
                    end
                end
                RUN: begin
                    done_q <= done_q | fall;
                    if (!(&cycles_q)) begin
                        cycles_q     <= cycles_inc;
                        cycles_sat_q <= &cycles_inc;
                    end
                end
                SUM: begin
                    // Overflow clips to all-ones; the flag stays set for the run.
                    total_q     <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
                    total_sat_q <= total_sat_q | sum_ext[SUM_W];
                    idx_q       <= idx_q + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign mon.busy        = busy_q;
    assign mon.done_mask   = done_q;
    assign mon.cycles      = cycles_q;
    assign mon.cycles_sat  = cycles_sat_q;
    assign mon.total       = total_q;
    assign mon.total_sat   = total_sat_q;
    assign mon.total_valid = total_valid_q;
endmodule

// File: tb/tb_multicore_monitor.sv
// Scoreboard bench: two monitors (wide and narrow counters/sum) share one stimulus;
// final results are pushed at run start and popped when total_valid rises.
module tb_multicore_monitor;
    localparam int CORES = 4;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multicore_monitor_if #(.CORES(CORES), .RESULT_W(8), .SUM_W(12), .CYCLE_W(16)) bus_a ();
    multicore_monitor_if #(.CORES(CORES), .RESULT_W(8), .SUM_W(9),  .CYCLE_W(4))  bus_b ();

    assign bus_b.start       = bus_a.start;
    assign bus_b.core_strobe = bus_a.core_strobe;
    assign bus_b.core_result = bus_a.core_result;

    multicore_monitor #(.CORES(CORES), .RESULT_W(8), .SUM_W(12), .CYCLE_W(16)) dut_a (
        .clk(clk), .reset(reset), .mon(bus_a.slave)
    );
    multicore_monitor #(.CORES(CORES), .RESULT_W(8), .SUM_W(9), .CYCLE_W(4)) dut_b (
        .clk(clk), .reset(reset), .mon(bus_b.slave)
    );

    typedef struct {
        int total_a;
        bit sat_a;
        int total_b;
        bit sat_b;
        int cycles_a;
        bit csat_a;
        int cycles_b;
        bit csat_b;
        int vcyc;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare final results whenever total_valid rises.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (bus_a.total_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_valid", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check("valid_cycle", cyc, e.vcyc);
                check("valid_b", bus_b.total_valid, 1);
                check("busy_a_done", bus_a.busy, 0);
                check("mask_a_done", bus_a.done_mask, 4'hf);
                check("total_a", bus_a.total, e.total_a);
                check("total_sat_a", bus_a.total_sat, e.sat_a);
                check("total_b", bus_b.total, e.total_b);
                check("total_sat_b", bus_b.total_sat, e.sat_b);
                check("cycles_a", bus_a.cycles, e.cycles_a);
                check("cycles_sat_a", bus_a.cycles_sat, e.csat_a);
                check("cycles_b", bus_b.cycles, e.cycles_b);
                check("cycles_sat_b", bus_b.cycles_sat, e.csat_b);
            end
        end
        prev_valid <= bus_a.total_valid;
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {bus_a.busy, bus_b.busy}, 0);
        check({tag, "_mask"}, {bus_a.done_mask, bus_b.done_mask}, 0);
        check({tag, "_cycles"}, {bus_a.cycles, bus_b.cycles}, 0);
        check({tag, "_csat"}, {bus_a.cycles_sat, bus_b.cycles_sat}, 0);
        check({tag, "_total"}, {bus_a.total, bus_b.total}, 0);
        check({tag, "_tsat"}, {bus_a.total_sat, bus_b.total_sat}, 0);
        check({tag, "_valid"}, {bus_a.total_valid, bus_b.total_valid}, 0);
    endtask

    // One full run: strobes fall at cycle f* after start; optional second fall
    // on core 2 and an ignored start inside the run at cycle start_k.
    task automatic do_run(input int f0, input int f1, input int f2, input int f3,
                          input logic [31:0] res, input int start_k, input bit dbl,
                          input int tot_a, input bit sat_a, input int tot_b, input bit sat_b);
        int   f[4];
        int   last;
        int   t0;
        int   exp_c;
        logic [3:0] s;
        logic [3:0] em;
        exp_t e;
        f[0] = f0; f[1] = f1; f[2] = f2; f[3] = f3;
        last = 0;
        for (int i = 0; i < 4; i++) if (f[i] > last) last = f[i];
        bus_a.core_result = res;
        bus_a.core_strobe = '1;
        bus_a.start = 1'b0;
        step();
        step();
        bus_a.start = 1'b1;
        step();
        bus_a.start = 1'b0;
        t0 = cyc;
        check("start_busy", bus_a.busy, 1);
        check("start_cycles", bus_a.cycles, 0);
        check("start_mask", bus_a.done_mask, 0);
        check("start_total", {bus_a.total, bus_a.total_sat, bus_a.cycles_sat}, 0);
        check("start_valid", bus_a.total_valid, 0);
        e.total_a  = tot_a;
        e.sat_a    = sat_a;
        e.total_b  = tot_b;
        e.sat_b    = sat_b;
        e.cycles_a = last;
        e.csat_a   = 1'b0;
        e.cycles_b = (last > 15) ? 15 : last;
        e.csat_b   = (last >= 15);
        e.vcyc     = t0 + last + CORES + 1;
        sb.push_back(e);
        for (int k = 1; k <= last + CORES + 2; k++) begin
            for (int i = 0; i < 4; i++) s[i] = (k < f[i]);
            if (dbl && k >= f[2] + 4 && k < f[2] + 8) s[2] = 1'b1;
            bus_a.core_strobe = s;
            bus_a.start = (k == start_k);
            step();
            for (int i = 0; i < 4; i++) em[i] = (k >= f[i]);
            exp_c = (k < last) ? k : last;
            check("run_mask", bus_a.done_mask, em);
            check("run_cycles_a", bus_a.cycles, exp_c);
            check("run_cycles_b", bus_b.cycles, (exp_c > 15) ? 15 : exp_c);
            check("run_busy", bus_a.busy, (k <= last + CORES));
        end
        bus_a.start = 1'b0;
        check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        reset = 1'b0;
        bus_a.start = 1'b0;
        bus_a.core_strobe = '1;
        bus_a.core_result = '0;
        #2;
        check_all_zero("reset");
        step();
        reset = 1'b1;
        step();
        step();

        // Falling edge while IDLE is ignored.
        bus_a.core_strobe = 4'b1101;
        step();
        check("idle_edge_mask", bus_a.done_mask, 0);
        check("idle_edge_busy", bus_a.busy, 0);
        bus_a.core_strobe = '1;
        step();

        // Basic run: results 3,5,7,11.
        do_run(10, 20, 20, 35, {8'd11, 8'd7, 8'd5, 8'd3}, 0, 1'b0, 26, 1'b0, 26, 1'b0);
        // Re-run from DONE with a double edge on core 2 and a start during RUN.
        do_run(10, 20, 20, 35, {8'd11, 8'd7, 8'd5, 8'd3}, 15, 1'b1, 26, 1'b0, 26, 1'b0);
        // Simultaneous edges, saturating sum on the narrow instance.
        do_run(5, 5, 5, 5, {8'd255, 8'd255, 8'd255, 8'd255}, 0, 1'b0, 1020, 1'b0, 511, 1'b1);

        // Reset in the middle of SUM.
        bus_a.core_strobe = '1;
        step();
        bus_a.start = 1'b1;
        step();
        bus_a.start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            bus_a.core_strobe = (k < 3) ? 4'hf : 4'h0;
            step();
        end
        check("pre_reset_total", bus_a.total, 510);
        reset = 1'b0;
        #1;
        check_all_zero("midsum_reset");
        step();
        reset = 1'b1;
        step();
        check_all_zero("post_reset");

        // Normal run after reset.
        do_run(2, 4, 6, 8, {8'd4, 8'd3, 8'd2, 8'd1}, 0, 1'b0, 10, 1'b0, 10, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
